// File: rtl/dsp48_preadd_macc_if.sv
// Operand/result bundle for dsp48_preadd_macc: signed A, D, B, C in and registered P out.
// The master drives operands, the slave (the DSP slice) drives the result.
interface dsp48_preadd_macc_if #(
  parameter int unsigned A_WIDTH = 25,
  parameter int unsigned D_WIDTH = 25,
  parameter int unsigned B_WIDTH = 18,
  parameter int unsigned C_WIDTH = 48,
  parameter int unsigned P_WIDTH = 48
);

  logic signed [A_WIDTH-1:0] A;
  logic signed [D_WIDTH-1:0] D;
  logic signed [B_WIDTH-1:0] B;
  logic signed [C_WIDTH-1:0] C;
  logic signed [P_WIDTH-1:0] P;

  modport master (
    output A,
    output D,
    output B,
    output C,
    input  P
  );

  modport slave (
    input  A,
    input  D,
    input  B,
    input  C,
    output P
  );

endinterface

// File: rtl/dsp48_preadd_macc.sv
// Three-stage signed pre-adder/multiply/add slice: P = (A + D) * B + C, wrapping at P_WIDTH.
// Optional clock enable port ce is added when DSP48_CE_EN is defined.
module dsp48_preadd_macc #(
  parameter int unsigned A_WIDTH = 25,
  parameter int unsigned D_WIDTH = 25,
  parameter int unsigned B_WIDTH = 18,
  parameter int unsigned C_WIDTH = 48,
  parameter int unsigned P_WIDTH = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef DSP48_CE_EN
  input  logic                 ce,
`endif
  dsp48_preadd_macc_if.slave   bus
);

  localparam int unsigned AD_W = ((A_WIDTH > D_WIDTH) ? A_WIDTH : D_WIDTH) + 1;
  localparam int unsigned M_W  = AD_W + B_WIDTH;

  // Stage 1: input capture
  logic signed [A_WIDTH-1:0] a1_q, a1_d;
  logic signed [D_WIDTH-1:0] d1_q, d1_d;
  logic signed [B_WIDTH-1:0] b1_q, b1_d;
  logic signed [C_WIDTH-1:0] c1_q, c1_d;

  // Stage 2: pre-add result plus delayed B and C
  logic signed [AD_W-1:0]    ad2_q, ad2_d;
  logic signed [B_WIDTH-1:0] b2_q, b2_d;
  logic signed [C_WIDTH-1:0] c2_q, c2_d;

  // Stage 3: result
  logic signed [P_WIDTH-1:0] p_q, p_d;

  logic signed [M_W-1:0]     m_c;
  logic                      en_c;

`ifdef DSP48_CE_EN
  assign en_c = ce;
`else
  assign en_c = 1'b1;
`endif

  // Next-state: every register holds unless the pipe is enabled
  always_comb begin
    a1_d  = a1_q;
    d1_d  = d1_q;
    b1_d  = b1_q;
    c1_d  = c1_q;
    ad2_d = ad2_q;
    b2_d  = b2_q;
    c2_d  = c2_q;
    p_d   = p_q;
    // Both factors are sign-extended to the product width so the low M_W bits are exact
    m_c   = M_W'(ad2_q) * M_W'(b2_q);
    if (en_c) begin
      a1_d  = bus.A;
      d1_d  = bus.D;
      b1_d  = bus.B;
      c1_d  = bus.C;
      ad2_d = AD_W'(a1_q) + AD_W'(d1_q);
      b2_d  = b1_q;
      c2_d  = c1_q;
      p_d   = P_WIDTH'(m_c) + P_WIDTH'(c2_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q  <= '0;
      d1_q  <= '0;
      b1_q  <= '0;
      c1_q  <= '0;
      ad2_q <= '0;
      b2_q  <= '0;
      c2_q  <= '0;
      p_q   <= '0;
    end else begin
      a1_q  <= a1_d;
      d1_q  <= d1_d;
      b1_q  <= b1_d;
      c1_q  <= c1_d;
      ad2_q <= ad2_d;
      b2_q  <= b2_d;
      c2_q  <= c2_d;
      p_q   <= p_d;
    end
  end

  assign bus.P = p_q;

endmodule

// File: tb/tb_dsp48_preadd_macc.sv
// Scoreboard bench for dsp48_preadd_macc: stimulus pushes expected P with a due edge,
// a monitor pops and compares as enabled edges elapse.
module tb_dsp48_preadd_macc;

  logic clk;
  logic rst_n;
  logic ce;

  dsp48_preadd_macc_if #(.A_WIDTH(25), .D_WIDTH(25), .B_WIDTH(18), .C_WIDTH(48), .P_WIDTH(48)) bus ();

  dsp48_preadd_macc #(.A_WIDTH(25), .D_WIDTH(25), .B_WIDTH(18), .C_WIDTH(48), .P_WIDTH(48)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef DSP48_CE_EN
    .ce    (ce),
`endif
    .bus   (bus.slave)
  );

  typedef struct {
    int          due;
    logic [47:0] p;
  } exp_t;

  exp_t sb[$];
  int   ecnt;
  int   n_vec;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Spec-level reference: (A + D) * B + C, kept modulo 2^48
  function automatic logic [47:0] ref_p(longint a, longint d, longint b, longint c);
    longint s;
    s = (a + d) * b + c;
    return s[47:0];
  endfunction

  task automatic check(string name, logic [47:0] got, logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Apply operands now; if they will be captured, schedule the expected result
  task automatic apply(longint a, longint d, longint b, longint c, logic [47:0] exp);
    exp_t e;
    bus.A = 25'(a);
    bus.D = 25'(d);
    bus.B = 18'(b);
    bus.C = 48'(c);
    if (rst_n && ce) begin
      e.due = ecnt + 3;
      e.p   = exp;
      sb.push_back(e);
    end
  endtask

  task automatic rand_vec();
    logic [24:0] ra, rd;
    logic [17:0] rb;
    logic [47:0] rc;
    longint a, d, b, c;
    ra = 25'($urandom);
    rd = 25'($urandom);
    rb = 18'($urandom);
    rc = {16'($urandom), 32'($urandom)};
    a = longint'($signed(ra));
    d = longint'($signed(rd));
    b = longint'($signed(rb));
    c = longint'($signed(rc));
    apply(a, d, b, c, ref_p(a, d, b, c));
  endtask

  // After release P stays 0 until the first captured sample arrives
  task automatic release_reset();
    exp_t e;
    rst_n = 1'b1;
    e.p   = '0;
    e.due = ecnt + 1;
    sb.push_back(e);
    e.due = ecnt + 2;
    sb.push_back(e);
  endtask

  // Monitor: count enabled edges, compare every entry that has come due
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst_n && ce) ecnt++;
      #1;
      while (sb.size() > 0 && sb[0].due <= ecnt) begin
        e = sb.pop_front();
        check($sformatf("p_due%0d", e.due), bus.P, e.p);
      end
    end
  end

  initial begin
    logic [47:0] held;
    ecnt  = 0;
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    ce    = 1'b1;
    bus.A = 25'(123);
    bus.D = 25'(-7);
    bus.B = 18'(99);
    bus.C = 48'(5555);

    // Reset with nonzero operands
    repeat (3) @(negedge clk);
    check("reset_hold", bus.P, 48'd0);

    @(negedge clk);
    release_reset();
    apply(longint'(10) <<< 16, -8, 5, longint'(1) <<< 16, 48'd3342296);
    @(negedge clk);
    apply(-(longint'(1) <<< 24), -(longint'(1) <<< 24), -(longint'(1) <<< 17), 0, 48'h0400_0000_0000);
    @(negedge clk);
    apply(0, 1, 1, 48'hFFFF_FFFF_FFFF, 48'd0);
    @(negedge clk);
    apply(0, 0, 0, -5, 48'hFFFF_FFFF_FFFB);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rand_vec();
    end

    // Mid-stream reset: in-flight results are dropped, P clears at once
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_reset", bus.P, 48'd0);
    @(negedge clk);
    check("reset_mid", bus.P, 48'd0);
    release_reset();
    rand_vec();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rand_vec();
    end

`ifdef DSP48_CE_EN
    // Pipe freeze: P must hold while operands keep changing
    @(negedge clk);
    ce   = 1'b0;
    held = bus.P;
    rand_vec();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ce_hold", bus.P, held);
      if (i < 3) rand_vec();
    end
    ce = 1'b1;
    rand_vec();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rand_vec();
    end
`endif

    // Steady operands give a steady result
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      apply(1000, -3000, -77, 12345, ref_p(1000, -3000, -77, 12345));
    end

    repeat (6) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d exp=0 pending results", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
